// File: rtl/copro_host_pkg.sv
// Shared types and default widths for the coprocessor host-side register master.
package copro_host_pkg;

    localparam int unsigned DATA_W_DEF = 256;
    localparam int unsigned SEL_W_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/copro_host_if.sv
// Command/response handshake plus coprocessor register port, bundled for the host master.
interface copro_host_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned SEL_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [SEL_W-1:0]  cmd_sel;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              readWrite;
    logic [SEL_W-1:0]  selectWrite;
    logic [DATA_W-1:0] writeBus;
    logic [SEL_W-1:0]  selectRead;
    logic [DATA_W-1:0] dataOut;

    modport master (
        input  cmd_valid, cmd_write, cmd_sel, cmd_data, rsp_ready, dataOut,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               readWrite, selectWrite, writeBus, selectRead
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_sel, cmd_data, rsp_ready, dataOut,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               readWrite, selectWrite, writeBus, selectRead
    );
endinterface

// File: rtl/copro_phase_timer.sv
// Loadable down-counter that stops at 1; done flags the last cycle of a timed phase.
module copro_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/copro_host_master.sv
// Host-side initiator: one command becomes a timed coprocessor write or read, then one response.
// Define COPRO_HOST_READBACK_EN to follow every write with a verifying read of the same register.
module copro_host_master
    import copro_host_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SEL_W      = SEL_W_DEF,
    parameter int unsigned WRITE_HOLD = 2,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic         clock,
    input  logic         reset,
    copro_host_if.master bus
);
    localparam int unsigned CNT_W = $clog2(max_u(WRITE_HOLD, READ_LAT) + 1);

    state_e            state_q, state_d;
    logic              accept;
    logic              tmr_load, tmr_done;
    logic [CNT_W-1:0]  tmr_val;
    logic [SEL_W-1:0]  sel_q, sel_d, selw_q, selw_d, selr_q, selr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, wbus_q, wbus_d;
    logic              rw_q, rw_d;
`ifdef COPRO_HOST_READBACK_EN
    logic              wr_q, wr_d, err_q, err_d;
`endif

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                state_d  = bus.cmd_write ? ST_WRITE : ST_READ;
                tmr_load = 1'b1;
                tmr_val  = bus.cmd_write ? CNT_W'(WRITE_HOLD) : CNT_W'(READ_LAT);
            end
            ST_WRITE: if (tmr_done) begin
`ifdef COPRO_HOST_READBACK_EN
                state_d  = ST_READ;
                tmr_load = 1'b1;
                tmr_val  = CNT_W'(READ_LAT);
`else
                state_d  = ST_RESP;
`endif
            end
            ST_READ:  if (tmr_done) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Coprocessor outputs are computed from the next state so the registers line up with it.
    always_comb begin
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef COPRO_HOST_READBACK_EN
        wr_d    = wr_q;
        err_d   = err_q;
`endif
        if (accept) begin
            sel_d   = bus.cmd_sel;
            wdata_d = bus.cmd_data;
            rdata_d = '0;
`ifdef COPRO_HOST_READBACK_EN
            wr_d    = bus.cmd_write;
            err_d   = 1'b0;
`endif
        end
        if ((state_q == ST_READ) && tmr_done) begin
            rdata_d = bus.dataOut;
`ifdef COPRO_HOST_READBACK_EN
            err_d   = wr_q && (bus.dataOut != wdata_q);
`endif
        end
        rw_d   = (state_d == ST_WRITE);
        selw_d = rw_d ? sel_d : '0;
        wbus_d = rw_d ? wdata_d : '0;
        selr_d = (state_d == ST_READ) ? sel_d : selr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rw_q    <= 1'b0;
            selw_q  <= '0;
            wbus_q  <= '0;
            selr_q  <= '0;
`ifdef COPRO_HOST_READBACK_EN
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rw_q    <= rw_d;
            selw_q  <= selw_d;
            wbus_q  <= wbus_d;
            selr_q  <= selr_d;
`ifdef COPRO_HOST_READBACK_EN
            wr_q    <= wr_d;
            err_q   <= err_d;
`endif
        end
    end

    copro_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rsp_valid   = (state_q == ST_RESP);
    assign bus.rsp_data    = rdata_q;
`ifdef COPRO_HOST_READBACK_EN
    assign bus.rsp_err     = err_q;
`else
    assign bus.rsp_err     = 1'b0;
`endif
    assign bus.readWrite   = rw_q;
    assign bus.selectWrite = selw_q;
    assign bus.writeBus    = wbus_q;
    assign bus.selectRead  = selr_q;
endmodule

// File: doc/copro_host_master.md
COPRO_HOST_MASTER -- requirements
Module: copro_host_master

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 256, register data width; SEL_W, 4, register select width; WRITE_HOLD, 2, cycles readWrite stays asserted (>=1); READ_LAT, 1, cycles selectRead is held stable before dataOut is sampled (>=1).
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted when high with cmd_valid.
- cmd_write, in, 1, 1 = register write, 0 = register read.
- cmd_sel, in, SEL_W, target register.
- cmd_data, in, DATA_W, write data.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, DATA_W, read data.
- rsp_err, out, 1, read-back mismatch.
- busy, out, 1, transaction in progress.
- readWrite, out, 1, coprocessor write strobe.
- selectWrite, out, SEL_W, coprocessor write select.
- writeBus, out, DATA_W, coprocessor write data.
- selectRead, out, SEL_W, coprocessor read select.
- dataOut, in, DATA_W, coprocessor read data.

Function
REQ-003 The block SHALL be the host-side initiator of the coprocessor register port: it converts one handshaked command into a timed write or read sequence and returns one handshaked response.
REQ-004 States SHALL be IDLE, WRITE, READ, RESP; busy = (state != IDLE); cmd_ready = (state == IDLE); there is no command pipelining.
REQ-005 IDLE: on cmd_valid && cmd_ready at edge N, the block SHALL latch cmd_write, cmd_sel and cmd_data, go to WRITE if cmd_write = 1 and to READ otherwise, and load the phase counter.
REQ-006 WRITE: readWrite = 1, selectWrite = latched sel, writeBus = latched data in cycles N+1 through N+WRITE_HOLD exactly; all three outputs are registered.
REQ-007 Outside WRITE, readWrite, selectWrite and writeBus SHALL be 0.
REQ-008 READ: selectRead = latched sel from the first READ cycle; dataOut SHALL be captured into rsp_data at the edge ending the READ_LAT-th READ cycle; selectRead then holds its last value until the next READ.
REQ-009 Plain read latency: rsp_valid first high in cycle N+READ_LAT+1.
REQ-010 Write latency (macro off): rsp_valid first high in cycle N+WRITE_HOLD+1, with rsp_data = 0.
REQ-011 RESP: rsp_valid = 1, and rsp_data and rsp_err SHALL stay stable until rsp_ready is sampled high; the block then returns to IDLE on the next cycle, with cmd_ready = 1.
REQ-012 rsp_ready held low SHALL stall indefinitely in RESP with no change on the coprocessor outputs.
REQ-013 Phase counter width SHALL be clog2(max(WRITE_HOLD, READ_LAT) + 1), and the counter SHALL count down to 1 with no wrap.

Reset
REQ-014 While reset is high at an edge, the block SHALL enter IDLE, and the following outputs SHALL be 0: rsp_valid, rsp_data, rsp_err, busy, readWrite, selectWrite, writeBus, selectRead; cmd_ready SHALL be 1 in the following cycle.
REQ-015 Reset mid-transaction SHALL abort the transaction: no response is produced, and readWrite is low in the cycle after the reset edge.

Configuration
REQ-016 With COPRO_HOST_READBACK_EN defined, WRITE SHALL be followed by READ on the same sel; rsp_data = captured dataOut; rsp_err = (captured dataOut != written data); write latency SHALL be N+WRITE_HOLD+READ_LAT+1.
REQ-017 Without COPRO_HOST_READBACK_EN, rsp_err SHALL be constant 0 and the write path of REQ-010 applies.

Structure
REQ-018 Package copro_host_pkg SHALL hold the state enum and the DATA_W/SEL_W default constants.
REQ-019 One sub-module, copro_phase_timer (loadable down-counter with done flag), SHALL be used for both the WRITE and READ phases.

Verification
REQ-020 With the macro off, write sel = 3, data = 4, rsp_ready = 1: readWrite high for exactly 2 cycles with selectWrite = 3 and writeBus = 4; rsp_valid in cycle N+3; all coprocessor write outputs then return to 0.
REQ-021 Read sel = 2 with dataOut = 0xABCD: selectRead = 2 from N+1; rsp_data = 0xABCD; rsp_valid in cycle N+2.
REQ-022 rsp_ready held low for 5 cycles: rsp_valid and rsp_data stay stable and cmd_ready stays 0; IDLE is entered the cycle after rsp_ready rises.
REQ-023 Reset asserted in the second WRITE cycle: readWrite is 0 in the next cycle, no rsp_valid is produced, and cmd_ready = 1.
REQ-024 With the macro on, write data = 5 to sel = 1 while dataOut returns 6: rsp_err = 1 and rsp_data = 6; when dataOut returns 5, rsp_err = 0.
